// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the IF/D memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, REQ, WAIT)
//   owner_t     : which requester owns the in-flight transaction
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Transaction watchdog for the memory port arbiter.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the count to zero (held while the arbiter is idle)
//   enable   : count one cycle per clock while a transaction is open
//   expired  : high in the cycle the count reaches TIMEOUT-1 while enabled
// TIMEOUT = 0 disables the watchdog (expired stays low).
module arb_timeout_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (count_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch (IF) and
// load/store (D) requesters of a single-cycle core.
// Ports:
//   clk, rst                 : clock and synchronous active-high reset
//   if_req/if_addr           : fetch request, held until if_valid
//   if_rdata/if_valid        : fetch data and one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_be             : load/store request, held until d_valid
//   d_rdata/d_valid          : load data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be         : registered memory request, stable until mem_gnt
//   mem_gnt                  : memory accepts the request
//   mem_rvalid/mem_rdata     : memory response (reads and writes)
//   stall                    : core must not advance
//   bus_err                  : one-cycle pulse when a transaction times out
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                bus_err
);

  arb_state_t state_q;
  owner_t     owner_q;
  logic       expired;
  logic       done;
  logic       abort;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == IDLE),
    .enable  (state_q != IDLE),
    .expired (expired)
  );

  // A response only counts once the request has been granted: in REQ it must
  // arrive together with mem_gnt, in WAIT on its own.
  assign done  = ((state_q == REQ) && mem_gnt && mem_rvalid) ||
                 ((state_q == WAIT) && mem_rvalid);
  assign abort = expired && !done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      bus_err  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // D wins: it belongs to the instruction already fetched. A request
          // is ignored while its own valid is high, as the core advances then.
          if (d_req && !d_valid) begin
            owner_q   <= OWN_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            state_q   <= REQ;
          end else if (if_req && !if_valid) begin
            owner_q   <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt && !mem_rvalid) begin
            mem_req <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
        end
        default: state_q <= IDLE;
      endcase

      // Completion and timeout abort both close the transaction; they take
      // precedence over the REQ->WAIT move above.
      if (done || abort) begin
        mem_req <= 1'b0;
        state_q <= IDLE;
        bus_err <= abort;
        if (owner_q == OWN_D) begin
          d_valid <= 1'b1;
          d_rdata <= done ? mem_rdata : '0;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= done ? mem_rdata : '0;
        end
      end
    end
  end

  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              bus_err;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              is_d;
    logic              chk;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   if_pulses  = 0;
  int   d_pulses   = 0;

  // Response monitor: every valid pulse pops the next expected completion.
  always @(negedge clk) begin
    if (!rst && (if_valid || d_valid || bus_err)) begin
      compared++;
      if (if_valid) if_pulses++;
      if (d_valid) d_pulses++;
      if (if_valid && d_valid) begin
        mismatched++;
        $display("FAIL dual_valid: if_valid=1 d_valid=1, required at most one");
      end else if (!if_valid && !d_valid) begin
        mismatched++;
        $display("FAIL stray_bus_err: bus_err=1 without valid pulse");
      end else if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_valid: if_valid=%b d_valid=%b, required no pulse",
                 if_valid, d_valid);
      end else begin
        mon_e = sb.pop_front();
        if (d_valid !== mon_e.is_d || bus_err !== mon_e.err ||
            (mon_e.chk && ((d_valid ? d_rdata : if_rdata) !== mon_e.rdata))) begin
          mismatched++;
          $display("FAIL response: got d=%b err=%b data=%h, required d=%b err=%b data=%h",
                   d_valid, bus_err, d_valid ? d_rdata : if_rdata,
                   mon_e.is_d, mon_e.err, mon_e.rdata);
        end
      end
    end
  end

  task automatic push_exp(input logic is_d, input logic chk, input logic [DATA_W-1:0] rdata,
                          input logic err);
    exp_t e;
    e.is_d  = is_d;
    e.chk   = chk;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, if_valid,
         d_rdata, d_valid, bus_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: mem_req=%b addr=%h if_valid=%b d_valid=%b bus_err=%b, required 0",
               mem_req, mem_addr, if_valid, d_valid, bus_err);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: mem_req=%b stall=%b, required 0 0", mem_req, stall);
    end
  endtask

  task automatic test_fetch();
    int ip;
    ip      = if_pulses;
    if_req  = 1'b1;
    if_addr = 32'h100;
    push_exp(1'b0, 1'b1, 32'h00500093, 1'b0);
    @(negedge clk);
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
      mismatched++;
      $display("FAIL fetch_launch: req=%b addr=%h we=%b be=%h, required 1 00000100 0 f",
               mem_req, mem_addr, mem_we, mem_be);
    end
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("FAIL fetch_stall_busy: stall=%b, required 1", stall);
    end
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00500093;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    compared++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h00500093) begin
      mismatched++;
      $display("FAIL fetch_done: if_valid=%b if_rdata=%h, required 1 00500093", if_valid, if_rdata);
    end
    compared++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL fetch_stall_drop: stall=%b mem_req=%b, required 0 0", stall, mem_req);
    end
    // if_req still high across the valid edge: must not relaunch.
    @(negedge clk);
    compared++;
    if (if_valid !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h00500093) begin
      mismatched++;
      $display("FAIL fetch_hold: if_valid=%b mem_req=%b if_rdata=%h, required 0 0 00500093",
               if_valid, mem_req, if_rdata);
    end
    if_req = 1'b0;
    compared++;
    if (if_pulses - ip !== 1) begin
      mismatched++;
      $display("FAIL fetch_pulses: %0d, required 1", if_pulses - ip);
    end
  endtask

  task automatic test_collision();
    int ip;
    int dp;
    ip      = if_pulses;
    dp      = d_pulses;
    if_req  = 1'b1;
    if_addr = 32'h104;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h2000;
    d_be    = 4'hF;
    push_exp(1'b1, 1'b1, 32'h11112222, 1'b0);
    push_exp(1'b0, 1'b1, 32'h33334444, 1'b0);
    @(negedge clk);
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b0) begin
      mismatched++;
      $display("FAIL coll_d_first: req=%b addr=%h we=%b, required 1 00002000 0",
               mem_req, mem_addr, mem_we);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    compared++;
    if (mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL coll_wait_req: mem_req=%b, required 0", mem_req);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11112222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    compared++;
    if (d_valid !== 1'b1 || stall !== 1'b1) begin
      mismatched++;
      $display("FAIL coll_d_done: d_valid=%b stall=%b, required 1 1", d_valid, stall);
    end
    // d_req held across its valid edge: IF must be picked next.
    @(negedge clk);
    d_req = 1'b0;
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_we !== 1'b0) begin
      mismatched++;
      $display("FAIL coll_if_second: req=%b addr=%h we=%b, required 1 00000104 0",
               mem_req, mem_addr, mem_we);
    end
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h33334444;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if_req     = 1'b0;
    @(negedge clk);
    compared++;
    if (if_pulses - ip !== 1 || d_pulses - dp !== 1 || mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL coll_pulses: if=%0d d=%0d mem_req=%b, required 1 1 0",
               if_pulses - ip, d_pulses - dp, mem_req);
    end
  endtask

  task automatic test_store();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h3000;
    d_wdata = 32'hDEADBEEF;
    d_be    = 4'h3;
    push_exp(1'b1, 1'b0, '0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      mem_gnt    = (k == 4);
      mem_rvalid = (k == 6);
      compared++;
      if (k <= 4) begin
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h3000 ||
            mem_wdata !== 32'hDEADBEEF || mem_be !== 4'h3 || d_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL store_req_c%0d: req=%b we=%b addr=%h wdata=%h be=%h, required 1 1 00003000 deadbeef 3",
                   k, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
        end
      end else begin
        if (mem_req !== 1'b0 || d_valid !== 1'b0 || stall !== 1'b1) begin
          mismatched++;
          $display("FAIL store_wait_c%0d: req=%b d_valid=%b stall=%b, required 0 0 1",
                   k, mem_req, d_valid, stall);
        end
      end
    end
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    compared++;
    if (d_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL store_done: d_valid=%b, required 1", d_valid);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    compared++;
    if (d_valid !== 1'b0 || mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL store_after: d_valid=%b mem_req=%b, required 0 0", d_valid, mem_req);
    end
  endtask

  task automatic test_timeout();
    if_req  = 1'b1;
    if_addr = 32'h200;
    push_exp(1'b0, 1'b1, '0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      compared++;
      if (mem_req !== 1'b1 || bus_err !== 1'b0) begin
        mismatched++;
        $display("FAIL timeout_req_c%0d: mem_req=%b bus_err=%b, required 1 0", k, mem_req, bus_err);
      end
    end
    @(negedge clk);
    compared++;
    if (mem_req !== 1'b0 || bus_err !== 1'b1 || if_valid !== 1'b1 || if_rdata !== '0) begin
      mismatched++;
      $display("FAIL timeout_abort: req=%b err=%b if_valid=%b rdata=%h, required 0 1 1 0",
               mem_req, bus_err, if_valid, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    compared++;
    if (bus_err !== 1'b0 || if_valid !== 1'b0 || mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_after: err=%b if_valid=%b req=%b, required 0 0 0",
               bus_err, if_valid, mem_req);
    end
  endtask

  task automatic test_reset_mid_wait();
    if_req  = 1'b1;
    if_addr = 32'h300;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst     = 1'b1;
    if_req  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, if_valid,
         d_rdata, d_valid, bus_err} !== '0) begin
      mismatched++;
      $display("FAIL rst_wait_outputs: req=%b addr=%h be=%h if_rdata=%h d_rdata=%h, required 0",
               mem_req, mem_addr, mem_be, if_rdata, d_rdata);
    end
    // Late response of the abandoned access lands in IDLE.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00000BAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    compared++;
    if (if_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_wait_late_rvalid: if_valid=%b d_valid=%b req=%b, required 0 0 0",
               if_valid, d_valid, mem_req);
    end
    if_req  = 1'b1;
    if_addr = 32'h304;
    push_exp(1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h304) begin
      mismatched++;
      $display("FAIL rst_wait_relaunch: req=%b addr=%h, required 1 00000304", mem_req, mem_addr);
    end
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    compared++;
    if (if_valid !== 1'b1 || if_rdata !== 32'hCAFEF00D) begin
      mismatched++;
      $display("FAIL rst_wait_served: if_valid=%b rdata=%h, required 1 cafef00d", if_valid, if_rdata);
    end
    if_req = 1'b0;
  endtask

  task automatic test_spurious();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00001234;
    @(negedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    compared++;
    if (if_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL spur_idle: if_valid=%b d_valid=%b req=%b, required 0 0 0",
               if_valid, d_valid, mem_req);
    end
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h400;
    d_be   = 4'hF;
    push_exp(1'b1, 1'b1, 32'h5555AAAA, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h00009999;
    @(negedge clk);
    compared++;
    if (mem_req !== 1'b1 || d_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL spur_no_gnt: req=%b d_valid=%b, required 1 0", mem_req, d_valid);
    end
    mem_gnt   = 1'b1;
    mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    compared++;
    if (d_valid !== 1'b1 || d_rdata !== 32'h5555AAAA) begin
      mismatched++;
      $display("FAIL spur_served: d_valid=%b d_rdata=%h, required 1 5555aaaa", d_valid, d_rdata);
    end
    d_req = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    if_req     = 1'b0;
    if_addr    = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    d_be       = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    test_reset();
    test_fetch();
    test_collision();
    test_store();
    test_timeout();
    test_reset_mid_wait();
    test_spurious();
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
